// File: rtl/coin_payer.sv
// coin_payer: pays an amount (0.5-unit steps) as a train of coin codes
// to a vend machine and reports the reply, or a timeout.
// Ports:
//   clk, rst (async, active-low)
//   start, amount   - payment request (sampled in IDLE)
//   vend_in         - vend machine reply
//   coin_out        - coin code (00 idle, 01 half, 10 one)
//   busy, done      - transaction status, one-cycle done pulse
//   result          - outcome (00 none, 10 vend, 11 vend+change)
//   coins_sent      - coins issued in the current/last transaction
module coin_payer #(
  parameter int AMT_W   = 4,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       vend_in,
  output logic [1:0]       coin_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       result,
  output logic [AMT_W-1:0] coins_sent
);

  localparam int CMAX = (GAP > TIMEOUT) ? GAP : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] GAP_END = CW'(GAP - 1);
  localparam logic [CW-1:0] TO_END  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] rem_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [1:0]       coin_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [1:0]       result_nxt;
  logic [AMT_W-1:0] sent_nxt;

  logic             reply;
  logic             active;
  logic [AMT_W-1:0] src;
  logic             big;

  // 01 is not a valid reply; only 10/11 end the transaction
  assign reply  = vend_in[1];
  assign active = (state == S_SEND) || (state == S_GAP)
               || (state == S_WAIT);

  // coin to issue on entry to SEND: from amount when leaving IDLE
  assign src = (state == S_IDLE) ? amount : remaining;
  assign big = |src[AMT_W-1:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_nxt = (amount != '0) ? S_SEND : S_DONE;
      end
      S_SEND: begin
        state_nxt = reply ? S_DONE : S_GAP;
      end
      S_GAP: begin
        if (reply)
          state_nxt = S_DONE;
        else if (cnt == GAP_END)
          state_nxt = (remaining != '0) ? S_SEND : S_WAIT;
      end
      S_WAIT: begin
        if (reply || cnt == TO_END)
          state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rem_nxt    = remaining;
    sent_nxt   = coins_sent;
    result_nxt = result;
    coin_nxt   = 2'b00;
    cnt_nxt    = '0;

    if (state == S_IDLE && start) begin
      rem_nxt    = amount;
      sent_nxt   = '0;
      result_nxt = 2'b00;
    end

    if (active && reply)
      result_nxt = vend_in;
    else if (state == S_WAIT && cnt == TO_END)
      result_nxt = 2'b00;

    // coin, counter and remaining update together as SEND is entered
    if (state_nxt == S_SEND) begin
      coin_nxt = big ? 2'b10 : 2'b01;
      rem_nxt  = src - (big ? AMT_W'(2) : AMT_W'(1));
      sent_nxt = ((state == S_IDLE) ? '0 : coins_sent)
               + AMT_W'(1);
    end

    if (state_nxt == state &&
        (state == S_GAP || state == S_WAIT))
      cnt_nxt = cnt + CW'(1);

    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining  <= '0;
      cnt        <= '0;
      coin_out   <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= 2'b00;
      coins_sent <= '0;
    end else begin
      remaining  <= rem_nxt;
      cnt        <= cnt_nxt;
      coin_out   <= coin_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      result     <= result_nxt;
      coins_sent <= sent_nxt;
    end
  end

endmodule
